ifu_inst_fetch: RTL and testbench

IFU_INST_FETCH -- requirements
Module: ifu_inst_fetch

---
 rtl/ifu_inst_fetch.sv | 177 +++++++++++++++++
 tb/tb_ifu_inst_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_inst_fetch.sv
// ifu_inst_fetch -- instruction fetch unit.
//
// Takes PC-change pulses from the PC counter, issues one read per PC on an
// AXI-lite style read channel, and presents the returned word to decode.
// At most one read is in flight. A redirect (flush_i) marks an in-flight
// read as dropped: the read still completes on the bus, but its data is
// discarded. A new PC arriving during that drain waits in a one-entry
// pending slot.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pc_i, pc_change_i         PC to fetch and its one-cycle strobe
//   flush_i                   redirect; kills the in-flight or held fetch
//   id_ready_i                decode accepts inst_o this cycle
//   arvalid_o/araddr_o/arready_i            read-address channel
//   rvalid_i/rdata_i/rresp_i/rready_o       read-data channel
//   inst_o/inst_pc_o/inst_valid_o/fetch_err_o  instruction to decode
//   stall_if_o                holds the PC counter while a fetch is busy
//   state_dbg_o               current FSM state (debug visibility)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holding valid keeps its payload stable and does not
// drop valid until the transfer happens; ready may toggle freely.
module ifu_inst_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RST_PC   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_change_i,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic        arvalid_o,
  output logic [31:0] araddr_o,
  input  logic        arready_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  output logic        rready_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        fetch_err_o,
  output logic        stall_if_o,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        err_q, err_d;

  // A PC strobe that arrives while a dropped read drains is parked here.
  logic pend_hit;
  assign pend_hit = drop_q & pc_change_i & ~flush_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (pc_change_i && !flush_i) begin
          pc_d    = pc_i;
          state_d = ADDR;
        end
      end

      ADDR, DATA: begin
        // A second redirect supersedes any PC parked after the first one.
        if (flush_i) begin
          drop_d       = 1'b1;
          pend_valid_d = 1'b0;
        end else if (pend_hit) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = pc_i;
        end

        if (state_q == ADDR) begin
          if (arready_i) state_d = DATA;
        end else if (rvalid_i) begin
          if (drop_q || flush_i) begin
            // Dropped beat: discard data, then fetch the parked PC if any.
            // A strobe in this very cycle is newer than the parked one.
            drop_d       = 1'b0;
            pend_valid_d = 1'b0;
            if (pend_hit) begin
              pc_d    = pc_i;
              state_d = ADDR;
            end else if (pend_valid_q && !flush_i) begin
              pc_d    = pend_pc_q;
              state_d = ADDR;
            end else begin
              state_d = IDLE;
            end
          end else begin
            inst_d    = (rresp_i != 2'b00) ? NOP_INST : rdata_i;
            inst_pc_d = pc_q;
            err_d     = (rresp_i != 2'b00);
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        // A redirect wins over acceptance: the held word is lost.
        if (flush_i) begin
          state_d = IDLE;
        end else if (id_ready_i) begin
          if (pc_change_i) begin
            pc_d    = pc_i;
            state_d = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RST_PC;
      drop_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RST_PC;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      err_q        <= err_d;
    end
  end

  assign arvalid_o    = (state_q == ADDR);
  assign araddr_o     = pc_q;
  assign rready_o     = (state_q == DATA);
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = (state_q == HOLD);
  assign fetch_err_o  = (state_q == HOLD) & err_q;
  assign state_dbg_o  = state_q;

  // Released for one cycle on a redirect and on a handoff to decode, so
  // the PC counter can present its next PC.
  assign stall_if_o = (state_q != IDLE) & ~flush_i &
                      ~((state_q == HOLD) & id_ready_i);

endmodule

// File: tb/tb_ifu_inst_fetch.sv
// Testbench for ifu_inst_fetch: directed scenarios followed by a randomized
// run against a transaction-level model of the fetch stream.
module tb_ifu_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_change_i;
  logic        flush_i;
  logic        id_ready_i;
  logic        arvalid_o;
  logic [31:0] araddr_o;
  logic        arready_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        fetch_err_o;
  logic        stall_if_o;
  logic [1:0]  state_dbg_o;

  int n_vec  = 0;
  int n_fail = 0;

  ifu_inst_fetch dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_change_i(pc_change_i),
    .flush_i(flush_i), .id_ready_i(id_ready_i),
    .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rready_o(rready_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .fetch_err_o(fetch_err_o),
    .stall_if_o(stall_if_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic idle_inputs();
    pc_change_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'd0; rresp_i = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    pc_i = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  typedef struct { logic [31:0] pc; logic killed; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } hold_t;
  req_t  req_q[$];   // requested PCs whose read beat has not completed
  hold_t exp_q[$];   // instructions that decode is expected to see next

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    pc_i = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", arvalid_o); end
    n_vec++; if (rready_o !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b expected 0", rready_o); end
    n_vec++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid_o); end
    n_vec++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err_o); end
    n_vec++; if (inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000013", inst_o); end
    n_vec++; if (inst_pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 80000000", inst_pc_o); end
    n_vec++; if (stall_if_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_if_o); end
  endtask

  task automatic test_basic();
    @(negedge clk); pc_i = 32'h8000_0000; pc_change_i = 1'b1; arready_i = 1'b1; id_ready_i = 1'b1; #1;
    n_vec++; if (stall_if_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_stall: got %b expected 0", stall_if_o); end
    @(negedge clk); pc_change_i = 1'b0; #1;
    n_vec++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL basic_arvalid_t1: got %b expected 1", arvalid_o); end
    n_vec++; if (araddr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_araddr: got %h expected 80000000", araddr_o); end
    @(negedge clk); rvalid_i = 1'b1; rdata_i = 32'h0010_0093; rresp_i = 2'b00; #1;
    n_vec++; if (rready_o !== 1'b1) begin n_fail++; $display("FAIL basic_rready_t2: got %b expected 1", rready_o); end
    @(negedge clk); rvalid_i = 1'b0; #1;
    n_vec++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid_t3: got %b expected 1", inst_valid_o); end
    n_vec++; if (inst_o !== 32'h0010_0093) begin n_fail++; $display("FAIL basic_inst: got %h expected 00100093", inst_o); end
    n_vec++; if (inst_pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_inst_pc: got %h expected 80000000", inst_pc_o); end
    n_vec++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", fetch_err_o); end
    @(negedge clk); #1;
    n_vec++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after_accept: got %b expected 0", inst_valid_o); end
    idle_inputs();
  endtask

  task automatic test_ar_stall();
    @(negedge clk); pc_i = 32'h8000_0100; pc_change_i = 1'b1; arready_i = 1'b0; id_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); pc_change_i = 1'b0; #1;
      n_vec++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL arstall_arvalid[%0d]: got %b expected 1", i, arvalid_o); end
      n_vec++; if (araddr_o !== 32'h8000_0100) begin n_fail++; $display("FAIL arstall_araddr[%0d]: got %h expected 80000100", i, araddr_o); end
      n_vec++; if (stall_if_o !== 1'b1) begin n_fail++; $display("FAIL arstall_stall[%0d]: got %b expected 1", i, stall_if_o); end
    end
    @(negedge clk); arready_i = 1'b1;
    @(negedge clk); arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0040_0213;
    @(negedge clk); rvalid_i = 1'b0; #1;
    n_vec++; if (inst_pc_o !== 32'h8000_0100) begin n_fail++; $display("FAIL arstall_inst_pc: got %h expected 80000100", inst_pc_o); end
    n_vec++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL arstall_valid: got %b expected 1", inst_valid_o); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_flush_drain();
    @(negedge clk); pc_i = 32'h8000_0200; pc_change_i = 1'b1; arready_i = 1'b1; id_ready_i = 1'b1;
    @(negedge clk); pc_change_i = 1'b0;
    @(negedge clk); flush_i = 1'b1; #1;
    n_vec++; if (stall_if_o !== 1'b0) begin n_fail++; $display("FAIL drain_flush_stall: got %b expected 0", stall_if_o); end
    @(negedge clk); flush_i = 1'b0; pc_i = 32'h8000_0040; pc_change_i = 1'b1; #1;
    n_vec++; if (stall_if_o !== 1'b1) begin n_fail++; $display("FAIL drain_stall: got %b expected 1", stall_if_o); end
    @(negedge clk); pc_change_i = 1'b0; #1;
    n_vec++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid_a: got %b expected 0", inst_valid_o); end
    @(negedge clk); rvalid_i = 1'b1; rdata_i = 32'hbad0_0bad; #1;
    n_vec++; if (rready_o !== 1'b1) begin n_fail++; $display("FAIL drain_rready: got %b expected 1", rready_o); end
    @(negedge clk); rvalid_i = 1'b0; #1;
    n_vec++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid_b: got %b expected 0", inst_valid_o); end
    n_vec++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL drain_arvalid: got %b expected 1", arvalid_o); end
    n_vec++; if (araddr_o !== 32'h8000_0040) begin n_fail++; $display("FAIL drain_araddr: got %h expected 80000040", araddr_o); end
    @(negedge clk); rvalid_i = 1'b1; rdata_i = 32'h0000_0111;
    @(negedge clk); rvalid_i = 1'b0; #1;
    n_vec++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_new_valid: got %b expected 1", inst_valid_o); end
    n_vec++; if (inst_pc_o !== 32'h8000_0040) begin n_fail++; $display("FAIL drain_new_pc: got %h expected 80000040", inst_pc_o); end
    n_vec++; if (inst_o !== 32'h0000_0111) begin n_fail++; $display("FAIL drain_new_inst: got %h expected 00000111", inst_o); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_rresp_err();
    @(negedge clk); pc_i = 32'h8000_0300; pc_change_i = 1'b1; arready_i = 1'b1; id_ready_i = 1'b1;
    @(negedge clk); pc_change_i = 1'b0;
    @(negedge clk); rvalid_i = 1'b1; rdata_i = 32'hdead_beef; rresp_i = 2'b10;
    @(negedge clk); rvalid_i = 1'b0; rresp_i = 2'b00; pc_i = 32'h8000_0304; pc_change_i = 1'b1; #1;
    n_vec++; if (inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL err_inst: got %h expected 00000013", inst_o); end
    n_vec++; if (fetch_err_o !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b expected 1", fetch_err_o); end
    n_vec++; if (stall_if_o !== 1'b0) begin n_fail++; $display("FAIL err_handoff_stall: got %b expected 0", stall_if_o); end
    @(negedge clk); pc_change_i = 1'b0; #1;
    n_vec++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL err_flag_cleared: got %b expected 0", fetch_err_o); end
    n_vec++; if (araddr_o !== 32'h8000_0304) begin n_fail++; $display("FAIL err_next_araddr: got %h expected 80000304", araddr_o); end
    @(negedge clk); rvalid_i = 1'b1; rdata_i = 32'h0020_0113;
    @(negedge clk); rvalid_i = 1'b0; #1;
    n_vec++; if (inst_o !== 32'h0020_0113) begin n_fail++; $display("FAIL err_next_inst: got %h expected 00200113", inst_o); end
    n_vec++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL err_next_flag: got %b expected 0", fetch_err_o); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_hold_flush();
    @(negedge clk); pc_i = 32'h8000_0400; pc_change_i = 1'b1; arready_i = 1'b1; id_ready_i = 1'b0;
    @(negedge clk); pc_change_i = 1'b0;
    @(negedge clk); rvalid_i = 1'b1; rdata_i = 32'h0030_0193;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rvalid_i = 1'b0; #1;
      n_vec++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, inst_valid_o); end
      n_vec++; if (inst_o !== 32'h0030_0193) begin n_fail++; $display("FAIL hold_inst[%0d]: got %h expected 00300193", i, inst_o); end
    end
    @(negedge clk); flush_i = 1'b1; id_ready_i = 1'b1;
    @(negedge clk); flush_i = 1'b0; id_ready_i = 1'b0; #1;
    n_vec++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_flush_valid: got %b expected 0", inst_valid_o); end
    n_vec++; if (stall_if_o !== 1'b0) begin n_fail++; $display("FAIL hold_flush_stall: got %b expected 0", stall_if_o); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); pc_i = 32'h8000_0500; pc_change_i = 1'b1; arready_i = 1'b0;
    @(negedge clk); pc_change_i = 1'b0; #1;
    n_vec++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_arvalid_before: got %b expected 1", arvalid_o); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    n_vec++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_arvalid: got %b expected 0", arvalid_o); end
    n_vec++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", inst_valid_o); end
    n_vec++; if (stall_if_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", stall_if_o); end
    n_vec++; if (inst_pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL rstmid_inst_pc: got %h expected 80000000", inst_pc_o); end
  endtask

  // ---------------- randomized run ----------------
  // The bench plays both the PC counter and the memory. Inputs are set at
  // the falling edge; every event recorded below happens at the next rising
  // edge. Model: each strobed PC yields one read of that address; its word
  // (or NOP on an error response) reaches decode in order unless a redirect
  // arrives first.
  task automatic test_random();
    logic [31:0] next_pc, beat_addr;
    logic        prev_flush, ar_done, beat_pending, exp_stall, exp_busy, exp_hold;
    logic [1:0]  resp;
    int          delay, accepted;
    req_t        r;
    apply_reset();
    req_q.delete(); exp_q.delete();
    next_pc = 32'h8000_1000; prev_flush = 1'b0; ar_done = 1'b0;
    beat_pending = 1'b0; delay = 0; accepted = 0; beat_addr = 32'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      flush_i     = !prev_flush && !(req_q.size() > 0 && req_q[0].killed) && ($urandom_range(0, 15) == 0);
      id_ready_i  = ($urandom_range(0, 3) != 0);
      arready_i   = 1'($urandom_range(0, 1));
      rvalid_i    = beat_pending && (delay == 0);
      resp        = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rresp_i     = resp;
      rdata_i     = rvalid_i ? mem_word(beat_addr) : $urandom;
      pc_change_i = 1'b0;
      #1;
      exp_hold  = (exp_q.size() != 0);
      exp_busy  = (req_q.size() != 0) || exp_hold;
      exp_stall = exp_busy && !flush_i && !(exp_hold && id_ready_i);
      n_vec++; if (stall_if_o !== exp_stall) begin n_fail++; $display("FAIL rnd_stall @%0d: got %b expected %b", cyc, stall_if_o, exp_stall); end
      n_vec++; if (inst_valid_o !== exp_hold) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b expected %b", cyc, inst_valid_o, exp_hold); end
      n_vec++; if (arvalid_o !== (req_q.size() > 0 && !ar_done)) begin n_fail++; $display("FAIL rnd_arvalid @%0d: got %b", cyc, arvalid_o); end
      n_vec++; if (rready_o !== ar_done) begin n_fail++; $display("FAIL rnd_rready @%0d: got %b expected %b", cyc, rready_o, ar_done); end
      if (exp_hold) begin
        n_vec++;
        if (inst_o !== exp_q[0].inst || inst_pc_o !== exp_q[0].pc || fetch_err_o !== exp_q[0].err) begin
          n_fail++;
          $display("FAIL rnd_inst @%0d: got %h/%h/%b expected %h/%h/%b", cyc, inst_o, inst_pc_o, fetch_err_o,
                   exp_q[0].inst, exp_q[0].pc, exp_q[0].err);
        end
      end
      // PC counter: strobe the redirect target right after a flush, else a
      // sequential PC whenever it is not stalled.
      if (prev_flush || (!stall_if_o && !flush_i && $urandom_range(0, 3) != 0)) begin
        pc_change_i = 1'b1;
        pc_i        = prev_flush ? ($urandom & 32'hffff_fffc) : next_pc;
        next_pc     = pc_i + 32'd4;
      end
      // events taken at the coming rising edge
      if (inst_valid_o && id_ready_i && !flush_i && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        accepted++;
      end
      if (flush_i) begin
        for (int i = 0; i < req_q.size(); i++) req_q[i].killed = 1'b1;
        exp_q.delete();
      end
      if (rvalid_i && rready_o) begin
        r = req_q.pop_front();
        ar_done = 1'b0; beat_pending = 1'b0;
        if (!r.killed) exp_q.push_back('{r.pc, (resp != 2'b00) ? 32'h0000_0013 : mem_word(r.pc), (resp != 2'b00)});
      end else if (beat_pending) begin
        delay--;
      end
      if (arvalid_o && arready_i) begin
        n_vec++;
        if (req_q.size() == 0 || ar_done) begin
          n_fail++; $display("FAIL rnd_unexpected_ar @%0d: addr %h", cyc, araddr_o);
        end else begin
          if (araddr_o !== req_q[0].pc) begin n_fail++; $display("FAIL rnd_araddr @%0d: got %h expected %h", cyc, araddr_o, req_q[0].pc); end
          ar_done = 1'b1; beat_pending = 1'b1; beat_addr = araddr_o;
          delay = $urandom_range(0, 3);
        end
      end
      if (pc_change_i) req_q.push_back('{pc_i, 1'b0});
      prev_flush = flush_i;
    end
    @(negedge clk); idle_inputs();
    n_vec++; if (accepted < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d accepted expected at least 200", accepted); end
  endtask

  initial begin
    rst = 1'b1;
    pc_i = 32'd0;
    idle_inputs();
    test_reset();
    test_basic();
    test_ar_stall();
    test_flush_drain();
    test_rresp_err();
    test_hold_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
